// File: rtl/sub_shift_stage.sv
// sub_shift_stage: SubBytes + ShiftRows stage of the AES-256 round datapath.
// A captured 128-bit state is substituted COLS_PER_CYCLE columns per clock
// through shared S-boxes. ShiftRows is then applied, and the result is held
// in an output register for the MixColumns stage under valid/ready.

// aes_sbox: FIPS-197 forward S-box, pure combinational table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module sub_shift_stage #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag
);
    // Number of SUB cycles needed to cover all four columns.
    localparam int N     = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // State viewed as [column][row] bytes; column 0 / row 0 land in the MSBs,
    // matching the flat 128-bit port layout directly.
    typedef logic [0:3][0:3][7:0] aes_state_t;
    typedef logic [0:3][7:0]      aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("sub_shift_stage: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    aes_state_t       st_reg;
    logic             last_reg;
    logic [TAG_W-1:0] tag_reg;

    aes_state_t       sub_state;
    aes_state_t       shifted;
    logic [1:0]       lane_col [COLS_PER_CYCLE];
    aes_col_t         lane_in  [COLS_PER_CYCLE];
    aes_col_t         lane_out [COLS_PER_CYCLE];
    logic             accept_ok;
    logic             capture;
    logic             done;

    // Pick the columns handled this cycle and route them to the S-box lanes.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            lane_col[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
            lane_in[k]  = st_reg[lane_col[k]];
        end
    end

    // Shared S-box instances: one per byte of each lane.
    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
            for (genvar r = 0; r < 4; r++) begin : g_row
                aes_sbox u_sbox (
                    .a (lane_in[k][r]),
                    .y (lane_out[k][r])
                );
            end
        end
    endgenerate

    // Merge the substituted lanes back into the working state, then ShiftRows.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any
        // conditional or partial update, so no path can infer a latch.
        sub_state = st_reg;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            sub_state[lane_col[k]] = lane_out[k];
        end
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[c][r] = sub_state[2'(c + r)][r];
            end
        end
    end

    assign done = (cnt == CNT_W'(N - 1));

    // Next-state and handshake decode.
    always_comb begin
        next_state = state;
        accept_ok  = 1'b0;
        case (state)
            IDLE: begin
                accept_ok = 1'b1;
                if (in_valid) next_state = SUB;
            end
            SUB: begin
                if (done) next_state = HOLD;
            end
            HOLD: begin
                accept_ok = out_ready;
                if (out_ready) next_state = in_valid ? SUB : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Nothing is accepted while reset is held.
    assign in_ready = rst_n & accept_ok;
    assign capture  = in_valid & in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Working state, column counter and output register updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            st_reg    <= '0;
            last_reg  <= 1'b0;
            tag_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        st_reg   <= in_data;
                        last_reg <= in_last;
                        tag_reg  <= in_tag;
                        cnt      <= '0;
                    end
                end
                SUB: begin
                    st_reg <= sub_state;
                    if (done) begin
                        cnt       <= '0;
                        out_data  <= shifted;
                        out_last  <= last_reg;
                        out_tag   <= tag_reg;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (capture) begin
                            st_reg   <= in_data;
                            last_reg <= in_last;
                            tag_reg  <= in_tag;
                            cnt      <= '0;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_shift_stage.sv
// tb_sub_shift_stage: directed self-checking bench for sub_shift_stage.
// Main instance uses COLS_PER_CYCLE=1; two extra instances (2 and 4 columns
// per cycle) repeat the FIPS-197 App.B vector to check latency scaling.
module tb_sub_shift_stage;
    localparam int TAG_W = 4;

    localparam logic [127:0] VEC_B   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] EXP_B   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VEC_Z   = 128'h0;
    localparam logic [127:0] EXP_Z   = 128'h63636363636363636363636363636363;
    localparam logic [127:0] VEC_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP_SEQ = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

    logic             clk;
    logic             rst_n;
    logic [127:0]     in_data;
    logic             in_last;
    logic [TAG_W-1:0] in_tag;

    logic             in_valid, in_ready, out_valid, out_ready, out_last;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    logic             in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [127:0]     out_data2;
    logic [TAG_W-1:0] out_tag2;

    logic             in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
    logic [127:0]     out_data4;
    logic [TAG_W-1:0] out_tag4;

    int checks = 0;
    int errors = 0;

    sub_shift_stage #(.COLS_PER_CYCLE(1), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_tag(out_tag)
    );

    sub_shift_stage #(.COLS_PER_CYCLE(2), .TAG_W(TAG_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_last(out_last2), .out_tag(out_tag2)
    );

    sub_shift_stage #(.COLS_PER_CYCLE(4), .TAG_W(TAG_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
        .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_last(out_last4), .out_tag(out_tag4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] held_data;
        logic         hold_ok;
        int           lat;

        rst_n      = 1'b0;
        in_valid   = 1'b0; in_valid2  = 1'b0; in_valid4  = 1'b0;
        out_ready  = 1'b0; out_ready2 = 1'b0; out_ready4 = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        in_tag     = '0;

        // Reset state.
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  128'h0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_out_tag",   out_tag,   4'h0);
        check("rst_in_ready",  in_ready,  1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1'b1);

        // App.B round 1 vector, out_ready high: 4-edge latency, 1-cycle pulse.
        in_data = VEC_B; in_tag = 4'd1; in_last = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("b_sub_in_ready", in_ready, 1'b0);
        step(); check("b_lat1_valid", out_valid, 1'b0);
        step(); check("b_lat2_valid", out_valid, 1'b0);
        step(); check("b_lat3_valid", out_valid, 1'b0);
        step(); check("b_lat4_valid", out_valid, 1'b1);
        check("b_data", out_data, EXP_B);
        check("b_tag",  out_tag,  4'd1);
        check("b_last", out_last, 1'b0);
        step();
        check("b_pulse_end", out_valid, 1'b0);
        check("b_idle_ready", in_ready, 1'b1);

        // All-zero final-round vector under 10 cycles of backpressure.
        in_data = VEC_Z; in_tag = 4'd14; in_last = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_data  = VEC_SEQ;
        repeat (4) step();
        check("z_valid", out_valid, 1'b1);
        check("z_data",  out_data,  EXP_Z);
        check("z_last",  out_last,  1'b1);
        check("z_tag",   out_tag,   4'd14);
        held_data = out_data;
        hold_ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== held_data || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        check("bp_hold_stable", hold_ok, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_follows", in_ready, 1'b1);
        step();
        check("bp_transfer_valid", out_valid, 1'b0);
        check("bp_data_kept", out_data, EXP_Z);
        check("bp_idle_ready", in_ready, 1'b1);

        // Back-to-back: second vector captured on the first one's transfer edge.
        in_data = VEC_SEQ; in_tag = 4'd3; in_last = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = VEC_B; in_tag = 4'd4;
        repeat (4) step();
        check("bb1_valid", out_valid, 1'b1);
        check("bb1_data",  out_data,  EXP_SEQ);
        check("bb1_tag",   out_tag,   4'd3);
        check("bb1_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("bb_gap0_valid", out_valid, 1'b0);
        check("bb_second_captured", in_ready, 1'b0);
        step(); check("bb_gap1_valid", out_valid, 1'b0);
        step(); check("bb_gap2_valid", out_valid, 1'b0);
        step(); check("bb_gap3_valid", out_valid, 1'b0);
        step();
        check("bb2_valid", out_valid, 1'b1);
        check("bb2_data",  out_data,  EXP_B);
        check("bb2_tag",   out_tag,   4'd4);
        step();
        check("bb2_done_valid", out_valid, 1'b0);

        // Reset during SUB discards the operation.
        in_data = VEC_B; in_tag = 4'd5; in_last = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("mr_valid",    out_valid, 1'b0);
        check("mr_data",     out_data,  128'h0);
        check("mr_in_ready", in_ready,  1'b0);
        check("mr_tag",      out_tag,   4'h0);
        rst_n = 1'b1;
        #1;
        check("mr_rel_ready", in_ready, 1'b1);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b0) hold_ok = 1'b0;
        end
        check("mr_no_output", hold_ok, 1'b1);
        in_data = VEC_SEQ; in_tag = 4'd6; in_last = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("mr_fresh_valid", out_valid, 1'b1);
        check("mr_fresh_data",  out_data,  EXP_SEQ);
        check("mr_fresh_tag",   out_tag,   4'd6);
        step();

        // COLS_PER_CYCLE=2: App.B, two-edge latency.
        in_data = VEC_B; in_tag = 4'd1; in_last = 1'b0;
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        check("c2_latency", 128'(lat), 128'd2);
        check("c2_data", out_data2, EXP_B);
        check("c2_tag",  out_tag2,  4'd1);
        step();
        check("c2_pulse_end", out_valid2, 1'b0);

        // COLS_PER_CYCLE=4: App.B, one-edge latency.
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        check("c4_latency", 128'(lat), 128'd1);
        check("c4_data", out_data4, EXP_B);
        check("c4_tag",  out_tag4,  4'd1);
        step();
        check("c4_pulse_end", out_valid4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub_shift_stage.md
Name: sub_shift_stage

Overview:
Upstream neighbour of the MixColumns stage in the AES-256 round datapath. Accepts a 128-bit state and applies SubBytes, processing COLS_PER_CYCLE columns per clock through shared S-box instances. It then applies ShiftRows and presents the result, registered, to the MixColumns stage. A valid/ready handshake runs on both sides. A final-round flag passes through so that downstream logic can bypass MixColumns in round 14.

Parameters:
COLS_PER_CYCLE, 1, columns substituted per clock; legal values 1, 2, 4; S-box instances = 4*COLS_PER_CYCLE; SUB phase length N = 4/COLS_PER_CYCLE cycles
TAG_W, 4, width of round tag carried alongside the state

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  upstream state valid
in_ready  out  1  block can accept input this cycle
in_data  in  128  state; column c = bits [127-32c -: 32], row 0 in MSB byte of each column
in_last  in  1  final-round flag
in_tag  in  TAG_W  round number tag
out_valid  out  1  out_data/out_last/out_tag valid
out_ready  in  1  downstream accepts
out_data  out  128  ShiftRows(SubBytes(in_data)), same byte layout
out_last  out  1  copy of captured in_last
out_tag  out  TAG_W  copy of captured in_tag

Behaviour:
- Reset (rst_n=0 at edge): state goes to IDLE, column counter = 0, out_valid=0, out_data=0, out_last=0, out_tag=0, internal state register = 0. While rst_n=0, in_ready is 0. Reset mid-SUB or mid-HOLD discards the operation; no output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, capture in_data/in_last/in_tag, set counter=0, go to SUB.
  - SUB: in_ready=0. Each edge substitutes columns [counter*COLS_PER_CYCLE +: COLS_PER_CYCLE] in place and advances counter. On the edge that completes column 3: load out_data with the ShiftRows result of the fully substituted state, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1; outputs held stable until out_ready=1. in_ready = out_ready (combinational).
    - On an edge with out_ready=1 and in_valid=1: the output transfer and the new capture happen in the same cycle; out_valid falls, state goes to SUB.
    - On an edge with out_ready=1 and in_valid=0: out_valid falls, state goes to IDLE.
- Latency: capture edge E0, then N SUB edges; out_valid is high after edge E0+N. Back-to-back throughput is one state per N+1 cycles.
- SubBytes: FIPS-197 S-box, pure combinational per byte (table or GF(2^8) inverse plus affine), no extra pipeline register.
- ShiftRows: out column c, row r = substituted column (c+r) mod 4, row r. Row 0 is unchanged; row r is rotated left by r.
- out_data, out_last and out_tag change only on the HOLD-entry edge (and on reset). They are not cleared when out_valid falls.
- in_data is ignored except on the capture edge. out_ready is ignored outside HOLD.
- Illegal COLS_PER_CYCLE: elaboration error.

Test Plan:
- FIPS-197 App.B round 1: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_tag=1, in_last=0, out_ready=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=1, out_last=0. out_valid rises exactly N edges after capture and lasts 1 cycle.
- in_data=0, in_last=1, in_tag=14 -> out_data=63636363636363636363636363636363, out_last=1, out_tag=14.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data and out_valid held stable, in_ready=0. Raise out_ready -> one transfer, then IDLE.
- Back-to-back: in_valid held high with out_ready=1 and two distinct vectors -> second vector captured on the same edge the first transfers. Outputs are N+1 cycles apart and both results are correct.
- Reset mid-SUB: assert rst_n=0 at SUB cycle 1 -> next cycle out_valid=0, out_data=0, in_ready=0. After release, in_ready=1 and a fresh vector gives the correct result.
- Repeat the App.B vector for COLS_PER_CYCLE=1, 2 and 4 -> identical out_data. Latency to out_valid is 4, 2 and 1 edges respectively.
